// File: rtl/emu_run_ctrl_pkg.sv
// Shared types and default widths for the emulation run/pause/step controller.
package emu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } run_state_e;

    localparam int unsigned DEF_NUM_CHAINS = 2;
    localparam int unsigned DEF_CNT_WIDTH  = 64;
    localparam int unsigned DEF_STEP_WIDTH = 32;

endpackage

// File: rtl/emu_step_counter.sv
// Loadable down-counter holding the number of DUT edges left in a bounded step.
module emu_step_counter
    import emu_run_ctrl_pkg::*;
#(
    parameter int unsigned STEP_WIDTH = DEF_STEP_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load_i,
    input  logic [STEP_WIDTH-1:0] load_val_i,
    input  logic                  dec_i,
    output logic                  last_o
);

    logic [STEP_WIDTH-1:0] val_q;
    logic [STEP_WIDTH-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = load_val_i;
        end else if (dec_i) begin
            val_d = val_q - STEP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign last_o = (val_q == STEP_WIDTH'(1));

endmodule

// File: rtl/emu_run_ctrl.sv
// Run/pause/step controller producing DUT and scan-chain clock-gate enables.
module emu_run_ctrl
    import emu_run_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = DEF_NUM_CHAINS,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int unsigned STEP_WIDTH = DEF_STEP_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pause_req,
    input  logic                  dut_stall,
    input  logic                  step_valid,
    output logic                  step_ready,
    input  logic [STEP_WIDTH-1:0] step_count,
    input  logic                  trig,
    input  logic                  trig_en,
    input  logic [NUM_CHAINS-1:0] scan_en,
    output logic                  dut_clk_en,
    output logic [NUM_CHAINS-1:0] chain_clk_en,
    output logic                  paused,
    output logic                  trig_hit,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    run_state_e           state_q;
    logic                 trig_hit_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    logic st_paused;
    logic run_ok;
    logic accept;
    logic trig_fire;
    logic step_last;

    assign st_paused = (state_q == ST_PAUSED);

    // resetn gates the enables so no edge escapes while reset is being sampled
    assign run_ok    = resetn && !st_paused && !pause_req && !dut_stall;
    assign step_ready = st_paused && !(|scan_en);
    assign accept    = step_valid && step_ready;
    assign trig_fire = run_ok && trig && trig_en;

    assign dut_clk_en   = run_ok;
    assign chain_clk_en = {NUM_CHAINS{run_ok}}
                        | ({NUM_CHAINS{st_paused && resetn}} & scan_en);

    emu_step_counter #(
        .STEP_WIDTH (STEP_WIDTH)
    ) u_step_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (st_paused && accept),
        .load_val_i (step_count),
        .dec_i      ((state_q == ST_STEP) && run_ok),
        .last_o     (step_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_PAUSED;
            trig_hit_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_PAUSED: begin
                    if (accept) begin
                        state_q    <= (step_count == '0) ? ST_RUN : ST_STEP;
                        trig_hit_q <= 1'b0;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (pause_req) begin
                        state_q <= ST_PAUSED;
                    end else if (trig_fire) begin
                        state_q    <= ST_PAUSED;
                        trig_hit_q <= 1'b1;
                    end else if ((state_q == ST_STEP) && run_ok && step_last) begin
                        state_q <= ST_PAUSED;
                    end
                end
                default: state_q <= ST_PAUSED;
            endcase
        end
    end

    assign cnt_d = run_ok ? cnt_q + CNT_WIDTH'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign paused      = st_paused;
    assign trig_hit    = trig_hit_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_emu_run_ctrl.sv
// Bench for emu_run_ctrl: vector table, directed corner cases, random vs model.
module tb_emu_run_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pause_req;
    logic        dut_stall;
    logic        step_valid;
    logic        step_ready;
    logic [31:0] step_count;
    logic        trig;
    logic        trig_en;
    logic [1:0]  scan_en;
    logic        dut_clk_en;
    logic [1:0]  chain_clk_en;
    logic        paused;
    logic        trig_hit;
    logic [63:0] cycle_count;

    always #5 clk = ~clk;

    emu_run_ctrl #(
        .NUM_CHAINS (2),
        .CNT_WIDTH  (64),
        .STEP_WIDTH (32)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pause_req    (pause_req),
        .dut_stall    (dut_stall),
        .step_valid   (step_valid),
        .step_ready   (step_ready),
        .step_count   (step_count),
        .trig         (trig),
        .trig_en      (trig_en),
        .scan_en      (scan_en),
        .dut_clk_en   (dut_clk_en),
        .chain_clk_en (chain_clk_en),
        .paused       (paused),
        .trig_hit     (trig_hit),
        .cycle_count  (cycle_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: "active" run with an edge budget (or unlimited)
    bit              m_active = 1'b0;
    bit              m_free   = 1'b0;
    longint unsigned m_left   = 0;
    bit              m_hit    = 1'b0;
    logic [63:0]     m_cnt    = '0;

    logic       obs_en;
    logic [1:0] obs_ch;
    logic       obs_rdy;
    logic       obs_pz;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic p, input logic s,
                         input logic v, input logic [31:0] c,
                         input logic t, input logic te,
                         input logic [1:0] sc);
        logic       e_en;
        logic       e_rdy;
        logic [1:0] e_ch;
        @(negedge clk);
        resetn = r; pause_req = p; dut_stall = s; step_valid = v;
        step_count = c; trig = t; trig_en = te; scan_en = sc;
        #1;
        e_rdy = !m_active && (sc == 2'b00);
        e_en  = r && m_active && !p && !s;
        e_ch  = !r ? 2'b00 : (e_en ? 2'b11 : (!m_active ? sc : 2'b00));
        chk("dut_clk_en", {63'd0, dut_clk_en}, {63'd0, e_en});
        chk("chain_clk_en", {62'd0, chain_clk_en}, {62'd0, e_ch});
        chk("step_ready", {63'd0, step_ready}, {63'd0, e_rdy});
        chk("paused", {63'd0, paused}, {63'd0, !m_active});
        chk("trig_hit", {63'd0, trig_hit}, {63'd0, m_hit});
        chk("cycle_count", cycle_count, m_cnt);
        obs_en = dut_clk_en; obs_ch = chain_clk_en;
        obs_rdy = step_ready; obs_pz = paused;
        @(posedge clk);
        if (!r) begin
            m_active = 0; m_free = 0; m_left = 0; m_hit = 0; m_cnt = '0;
        end else if (!m_active) begin
            if (v && e_rdy) begin
                m_active = 1; m_free = (c == 0); m_left = c; m_hit = 0;
            end
        end else if (p) begin
            m_active = 0;
        end else if (e_en) begin
            m_cnt = m_cnt + 1;
            if (t && te) begin
                m_active = 0; m_hit = 1;
            end else if (!m_free) begin
                m_left = m_left - 1;
                if (m_left == 0) m_active = 0;
            end
        end
    endtask

    task automatic idle(input logic p, input logic s, input logic [1:0] sc);
        drive(1'b1, p, s, 1'b0, 32'd0, 1'b0, 1'b0, sc);
    endtask

    task automatic start(input logic [31:0] c);
        drive(1'b1, 1'b0, 1'b0, 1'b1, c, 1'b0, 1'b0, 2'b00);
    endtask

    typedef struct {
        logic p, s, v;
        logic [31:0] c;
        logic t, te;
        logic [1:0] sc;
        logic x_en;
        logic [1:0] x_ch;
        logic x_rdy, x_pz;
    } vec_t;

    vec_t tbl[12];

    int n_en;
    int first_i;
    logic [63:0] base;

    initial begin
        tbl[0]  = '{0,0,0,32'd0,0,0,2'b01, 0,2'b01,0,1};
        tbl[1]  = '{0,0,1,32'd2,0,0,2'b00, 0,2'b00,1,1};
        tbl[2]  = '{0,1,0,32'd0,0,0,2'b00, 0,2'b00,0,0};
        tbl[3]  = '{0,0,0,32'd0,0,0,2'b11, 1,2'b11,0,0};
        tbl[4]  = '{0,0,0,32'd0,0,0,2'b00, 1,2'b11,0,0};
        tbl[5]  = '{1,0,0,32'd0,0,0,2'b00, 0,2'b00,1,1};
        tbl[6]  = '{1,0,1,32'd0,0,0,2'b00, 0,2'b00,1,1};
        tbl[7]  = '{0,0,0,32'd0,0,0,2'b00, 1,2'b11,0,0};
        tbl[8]  = '{0,0,0,32'd0,1,0,2'b00, 1,2'b11,0,0};
        tbl[9]  = '{0,1,0,32'd0,1,1,2'b00, 0,2'b00,0,0};
        tbl[10] = '{0,0,0,32'd0,1,1,2'b00, 1,2'b11,0,0};
        tbl[11] = '{0,0,0,32'd0,0,0,2'b00, 0,2'b00,1,1};

        resetn = 0; pause_req = 0; dut_stall = 0; step_valid = 0;
        step_count = 0; trig = 0; trig_en = 0; scan_en = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_paused", {63'd0, paused}, 64'd1);
        chk("rst_dut_en", {63'd0, dut_clk_en}, 64'd0);
        chk("rst_chain_en", {62'd0, chain_clk_en}, 64'd0);
        chk("rst_count", cycle_count, 64'd0);
        chk("rst_trig_hit", {63'd0, trig_hit}, 64'd0);

        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].p, tbl[i].s, tbl[i].v, tbl[i].c,
                  tbl[i].t, tbl[i].te, tbl[i].sc);
            chk($sformatf("tbl%0d_en", i), {63'd0, obs_en}, {63'd0, tbl[i].x_en});
            chk($sformatf("tbl%0d_ch", i), {62'd0, obs_ch}, {62'd0, tbl[i].x_ch});
            chk($sformatf("tbl%0d_rdy", i), {63'd0, obs_rdy}, {63'd0, tbl[i].x_rdy});
            chk($sformatf("tbl%0d_pz", i), {63'd0, obs_pz}, {63'd0, tbl[i].x_pz});
        end
        chk("tbl_count", cycle_count, 64'd5);

        // Bounded step of 5 edges
        base = m_cnt;
        start(32'd5);
        n_en = 0; first_i = -1;
        for (int i = 0; i < 8; i++) begin
            idle(1'b0, 1'b0, 2'b00);
            if (obs_en) begin
                if (first_i < 0) first_i = i;
                n_en++;
            end
        end
        chk("step5_edges", 64'(n_en), 64'd5);
        chk("step5_first", 64'(first_i), 64'd0);
        chk("step5_count", cycle_count, base + 64'd5);

        // Step of 10 with stall on edges 3-4
        base = m_cnt;
        start(32'd10);
        n_en = 0;
        for (int i = 0; i < 12; i++) begin
            idle(1'b0, (i == 2 || i == 3), 2'b00);
            if (obs_en) n_en++;
            if (i < 11) chk("step10_running", {63'd0, obs_pz}, 64'd0);
        end
        #1;
        chk("step10_edges", 64'(n_en), 64'd10);
        chk("step10_paused", {63'd0, paused}, 64'd1);
        chk("step10_count", cycle_count, base + 64'd10);

        // Free run, pause on cycle 7, then a step of 3
        base = m_cnt;
        start(32'd0);
        for (int i = 1; i <= 7; i++) begin
            idle((i == 7), 1'b0, 2'b00);
            if (i == 7) chk("free_pause_en", {63'd0, obs_en}, 64'd0);
        end
        #1;
        chk("free_paused", {63'd0, paused}, 64'd1);
        chk("free_count", cycle_count, base + 64'd6);
        start(32'd3);
        repeat (4) idle(1'b0, 1'b0, 2'b00);
        chk("free_step3_count", cycle_count, base + 64'd9);

        // Trigger on 4th edge of a 20-step
        base = m_cnt;
        start(32'd20);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, (i == 4), 1'b1, 2'b00);
        end
        #1;
        chk("trig_paused", {63'd0, paused}, 64'd1);
        chk("trig_hit_set", {63'd0, trig_hit}, 64'd1);
        chk("trig_count", cycle_count, base + 64'd4);
        start(32'd1);
        #1;
        chk("trig_hit_clr", {63'd0, trig_hit}, 64'd0);
        idle(1'b0, 1'b0, 2'b00);

        // Scan in PAUSED for 8 cycles, then scan during RUN
        base = m_cnt;
        for (int i = 0; i < 8; i++) begin
            idle(1'b0, 1'b0, 2'b10);
            chk("scan_ch", {62'd0, obs_ch}, 64'd2);
            chk("scan_rdy", {63'd0, obs_rdy}, 64'd0);
        end
        chk("scan_count", cycle_count, base);
        start(32'd0);
        for (int i = 0; i < 4; i++) begin
            idle((i == 3), (i == 1), 2'b11);
            chk("run_scan_ch", {62'd0, obs_ch}, {62'd0, {2{obs_en}}});
        end

        // Reset in the middle of a step with 7 edges left
        start(32'd10);
        repeat (3) idle(1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00);
        chk("rst_mid_en", {63'd0, obs_en}, 64'd0);
        n_en = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b0, 1'b0, 2'b00);
            if (obs_en) n_en++;
        end
        chk("rst_mid_edges", 64'(n_en), 64'd0);
        chk("rst_mid_count", cycle_count, 64'd0);
        chk("rst_mid_paused", {63'd0, paused}, 64'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] c;
            c = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF
                                            : 32'($urandom_range(0, 6));
            drive($urandom_range(0, 63) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0,
                  c,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
